rx_frame_ctrl: RTL and testbench

- Receive-frame sequencer downstream of the RMII-to-MII nibble converter in MAC_rx.
- Consumes the converter's 4-bit nibble stream plus a carrier/valid qualifier and hunts for preamble/SFD.
- Assembles payload bytes low-nibble-first and tracks frame length.
- Reports end-of-frame status (length, short/long/alignment errors) to the MAC rx buffer logic.

---
 rtl/rx_frame_ctrl_if.sv | 31 +++
 rtl/rx_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_if.sv
// Nibble-in / byte-and-status-out bundle between the RMII-to-MII converter,
// the receive-frame sequencer and the MAC rx buffer logic.
interface rx_frame_ctrl_if #(
    parameter int LW = 11
) ();
    logic          NIB_VLD;
    logic [3:0]    NIB;
    logic [7:0]    BYTE_DO;
    logic          BYTE_VLD;
    logic          SOF;
    logic          DONE;
    logic [LW-1:0] LEN;
    logic          ERR_SHORT;
    logic          ERR_LONG;
    logic          ERR_ALIGN;
    logic          BUSY;

    // Nibble source side (converter / testbench)
    modport master (
        output NIB_VLD, NIB,
        input  BYTE_DO, BYTE_VLD, SOF, DONE, LEN,
               ERR_SHORT, ERR_LONG, ERR_ALIGN, BUSY
    );

    // Sequencer side
    modport slave (
        input  NIB_VLD, NIB,
        output BYTE_DO, BYTE_VLD, SOF, DONE, LEN,
               ERR_SHORT, ERR_LONG, ERR_ALIGN, BUSY
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive-frame sequencer: hunts preamble/SFD in the nibble stream, packs
// payload bytes low-nibble-first and reports length/error status per frame.
module rx_frame_ctrl #(
    parameter int MIN_PRE = 2,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LW      = 11
) (
    input logic           CLK,
    input logic           RT,
    rx_frame_ctrl_if.slave bus
);
    localparam int PW = (MIN_PRE < 1) ? 1 : $clog2(MIN_PRE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t        state_reg;
    logic          armed_reg;
    logic [PW-1:0] pre_cnt_reg;
    logic          phase_reg;
    logic [3:0]    low_reg;
    logic [LW-1:0] cnt_reg;
    logic [7:0]    byte_reg;
    logic          byte_vld_reg;
    logic          sof_reg;
    logic          done_reg;
    logic [LW-1:0] len_reg;
    logic          err_short_reg;
    logic          err_long_reg;
    logic          err_align_reg;

    // Frame sequencer; strobes default low each cycle, status held between DONEs
    always_ff @(posedge CLK) begin
        if (RT) begin
            state_reg     <= IDLE;
            armed_reg     <= 1'b0;
            pre_cnt_reg   <= '0;
            phase_reg     <= 1'b0;
            low_reg       <= '0;
            cnt_reg       <= '0;
            byte_reg      <= '0;
            byte_vld_reg  <= 1'b0;
            sof_reg       <= 1'b0;
            done_reg      <= 1'b0;
            len_reg       <= '0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
            err_align_reg <= 1'b0;
        end else begin
            byte_vld_reg <= 1'b0;
            sof_reg      <= 1'b0;
            done_reg     <= 1'b0;

            // A carrier gap proves we are between frames, so re-arm the hunt
            if (!bus.NIB_VLD) begin
                armed_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (armed_reg && bus.NIB_VLD && bus.NIB == 4'h5) begin
                        state_reg   <= PRE;
                        pre_cnt_reg <= PW'(1);
                    end
                end

                PRE: begin
                    if (!bus.NIB_VLD) begin
                        state_reg <= IDLE;
                    end else if (bus.NIB == 4'h5) begin
                        if (pre_cnt_reg < PW'(MIN_PRE)) begin
                            pre_cnt_reg <= pre_cnt_reg + PW'(1);
                        end
                    end else if (bus.NIB == 4'hD && pre_cnt_reg >= PW'(MIN_PRE)) begin
                        state_reg <= DATA;
                        phase_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        // Bad preamble: give up and wait for a carrier gap
                        state_reg <= IDLE;
                        armed_reg <= 1'b0;
                    end
                end

                DATA: begin
                    if (!bus.NIB_VLD) begin
                        state_reg     <= IDLE;
                        done_reg      <= 1'b1;
                        len_reg       <= cnt_reg;
                        err_align_reg <= phase_reg;
                        err_short_reg <= (cnt_reg < LW'(MIN_LEN));
                        err_long_reg  <= 1'b0;
                    end else if (!phase_reg) begin
                        low_reg   <= bus.NIB;
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        if (cnt_reg == LW'(MAX_LEN)) begin
                            // Oversize: report now, swallow the rest of the frame
                            state_reg     <= DROP;
                            done_reg      <= 1'b1;
                            len_reg       <= LW'(MAX_LEN);
                            err_long_reg  <= 1'b1;
                            err_short_reg <= (MAX_LEN < MIN_LEN);
                            err_align_reg <= 1'b0;
                        end else begin
                            byte_reg     <= {bus.NIB, low_reg};
                            byte_vld_reg <= 1'b1;
                            sof_reg      <= (cnt_reg == '0);
                            cnt_reg      <= cnt_reg + LW'(1);
                        end
                    end
                end

                DROP: begin
                    if (!bus.NIB_VLD) begin
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.BYTE_DO   = byte_reg;
    assign bus.BYTE_VLD  = byte_vld_reg;
    assign bus.SOF       = sof_reg;
    assign bus.DONE      = done_reg;
    assign bus.LEN       = len_reg;
    assign bus.ERR_SHORT = err_short_reg;
    assign bus.ERR_LONG  = err_long_reg;
    assign bus.ERR_ALIGN = err_align_reg;
    assign bus.BUSY      = (state_reg != IDLE);
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Testbench for rx_frame_ctrl: directed frames plus randomized frames checked
// against a frame-level reference model (preamble rule, byte packing, status).
module tb_rx_frame_ctrl;
    localparam int MIN_PRE = 2;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 100;
    localparam int LW      = 11;

    logic CLK = 1'b0;
    logic RT  = 1'b1;

    rx_frame_ctrl_if #(.LW(LW)) bus ();

    rx_frame_ctrl #(
        .MIN_PRE(MIN_PRE),
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .LW     (LW)
    ) dut (
        .CLK(CLK),
        .RT (RT),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Observed traffic, collected away from the active edge
    logic [7:0] byte_q[$];
    bit         sof_q[$];
    int         done_cnt    = 0;
    int         overlap_cnt = 0;

    // Stimulus burst and expected results
    logic [3:0] nib_q[$];
    logic [7:0] exp_bytes[$];
    bit         exp_done, exp_short, exp_long, exp_align;
    int         exp_len;

    always @(negedge CLK) begin
        if (bus.BYTE_VLD) begin
            byte_q.push_back(bus.BYTE_DO);
            sof_q.push_back(bus.SOF);
        end
        if (bus.DONE) done_cnt++;
        if (bus.DONE && bus.BYTE_VLD) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] n);
        @(posedge CLK);
        #1;
        bus.NIB_VLD = v;
        bus.NIB     = n;
    endtask

    // Burst = pre x 0x5, terminator nibble, nbytes payload bytes, optional odd nibble
    task automatic build(input int pre, input logic [3:0] term, input int nbytes,
                         input bit extra, input bit rnd);
        nib_q.delete();
        repeat (pre) nib_q.push_back(4'h5);
        nib_q.push_back(term);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : 8'(i);
            nib_q.push_back(b[3:0]);
            nib_q.push_back(b[7:4]);
        end
        if (extra) nib_q.push_back(4'($urandom));
    endtask

    // Frame-level reference: a run of >= MIN_PRE 0x5 then 0xD opens a frame;
    // the remaining nibbles pair up into bytes, the first MAX_LEN are delivered.
    task automatic model_frame();
        int p;
        p = 0;
        exp_bytes.delete();
        exp_done = 0; exp_short = 0; exp_long = 0; exp_align = 0; exp_len = 0;
        while (p < nib_q.size() && nib_q[p] == 4'h5) p++;
        if (p >= MIN_PRE && p < nib_q.size() && nib_q[p] == 4'hD) begin
            int n, nb;
            n  = nib_q.size() - p - 1;
            nb = n / 2;
            exp_done = 1;
            if (nb > MAX_LEN) begin
                exp_len   = MAX_LEN;
                exp_long  = 1;
                exp_short = (MAX_LEN < MIN_LEN);
                nb        = MAX_LEN;
            end else begin
                exp_len   = nb;
                exp_short = (nb < MIN_LEN);
                exp_align = (n % 2 == 1);
            end
            for (int i = 0; i < nb; i++)
                exp_bytes.push_back({nib_q[p + 2 + 2 * i], nib_q[p + 1 + 2 * i]});
        end
    endtask

    task automatic check_queues(input string tag);
        int n;
        check({tag, ":nbytes"}, byte_q.size(), exp_bytes.size());
        n = (byte_q.size() < exp_bytes.size()) ? byte_q.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s:byte%0d", tag, i), byte_q[i], exp_bytes[i]);
            check($sformatf("%s:sof%0d", tag, i), sof_q[i], (i == 0));
        end
        check({tag, ":done_cnt"}, done_cnt, exp_done);
        check({tag, ":overlap"}, overlap_cnt, 0);
        check({tag, ":busy_idle"}, bus.BUSY, 1'b0);
        byte_q.delete();
        sof_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
    endtask

    task automatic send_nibbles();
        foreach (nib_q[i]) drive(1'b1, nib_q[i]);
    endtask

    // Full frame: model, drive burst, check DONE one cycle after carrier drop
    task automatic run_frame(input string tag);
        model_frame();
        send_nibbles();
        drive(1'b0, 4'h0);
        @(posedge CLK);
        @(negedge CLK);
        check({tag, ":done"}, bus.DONE, (exp_done && !exp_long));
        if (exp_done) begin
            check({tag, ":len"},   bus.LEN,       exp_len);
            check({tag, ":short"}, bus.ERR_SHORT, exp_short);
            check({tag, ":long"},  bus.ERR_LONG,  exp_long);
            check({tag, ":align"}, bus.ERR_ALIGN, exp_align);
        end
        repeat (3) drive(1'b0, 4'h0);
        check_queues(tag);
        $display("frame %s: %0d nibbles, expect done=%0d len=%0d bytes=%0d",
                 tag, nib_q.size(), exp_done, exp_len, exp_bytes.size());
    endtask

    int lens[10] = '{0, 1, 20, 63, 64, 65, 99, 100, 101, 130};

    initial begin
        bus.NIB_VLD = 1'b0;
        bus.NIB     = 4'h0;
        RT          = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst:byte_vld", bus.BYTE_VLD,  1'b0);
        check("rst:byte_do",  bus.BYTE_DO,   8'h00);
        check("rst:sof",      bus.SOF,       1'b0);
        check("rst:done",     bus.DONE,      1'b0);
        check("rst:len",      bus.LEN,       0);
        check("rst:errs",     {bus.ERR_SHORT, bus.ERR_LONG, bus.ERR_ALIGN}, 3'b000);
        check("rst:busy",     bus.BUSY,      1'b0);
        @(posedge CLK);
        #1;
        RT = 1'b0;
        repeat (2) drive(1'b0, 4'h0);

        build(14, 4'hD, 64, 0, 0);  run_frame("good64");
        build(14, 4'hD, 20, 0, 1);  run_frame("short20");
        build(14, 4'hD, 65, 1, 1);  run_frame("align65");
        build(14, 4'hD, 150, 0, 1); run_frame("long150");
        build(8,  4'hD, 64, 0, 1);  run_frame("after_long");
        build(1,  4'hD, 10, 0, 1);  run_frame("pre_short");
        build(2,  4'h3, 10, 0, 1);  run_frame("pre_bad");
        build(2,  4'hD, 0,  0, 0);  run_frame("empty");

        // Reset mid-frame after 30 bytes; carrier stays up carrying 0x5
        build(14, 4'hD, 30, 0, 1);
        model_frame();
        exp_done = 0;
        send_nibbles();
        @(posedge CLK);
        #1;
        RT = 1'b1;
        bus.NIB_VLD = 1'b1;
        bus.NIB     = 4'h5;
        @(posedge CLK);
        #1;
        RT = 1'b0;
        @(negedge CLK);
        check("midrst:byte_vld", bus.BYTE_VLD, 1'b0);
        check("midrst:done",     bus.DONE,     1'b0);
        check("midrst:len",      bus.LEN,      0);
        check("midrst:busy",     bus.BUSY,     1'b0);
        repeat (40) drive(1'b1, 4'h5);
        repeat (4) drive(1'b0, 4'h0);
        check_queues("midrst");
        $display("frame midrst: 30 bytes before reset, expect no done");
        build(10, 4'hD, 70, 0, 1); run_frame("post_rst");

        for (int f = 0; f < 12; f++) begin
            int pre, nb;
            logic [3:0] term;
            pre  = $urandom_range(1, 8);
            term = ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hD;
            nb   = lens[$urandom_range(0, 9)];
            build(pre, term, nb, 1'($urandom_range(0, 1)), 1);
            run_frame($sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
